clk_en_irq_gen: RTL and testbench

CLK_EN_IRQ_GEN -- requirements
Module: clk_en_irq_gen

---
 rtl/clk_en_irq_gen.sv | 128 ++++++++++++
 tb/tb_clk_en_irq_gen.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_irq_gen.sv
// clk_en_irq_gen: a bank of programmable clock-enable dividers. Each channel
// produces a one-cycle enable pulse every div+1 clocks plus a square-wave
// phase. One selectable channel clocks an interrupt sequencer that raises irq
// either for one tick period per sequence (windowed) or until acknowledged
// (latched, with a sticky overrun flag).
module clk_en_irq_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int IRQ_W  = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        run,
  input  logic [NUM_CH*CNT_W-1:0]                     div,
  output logic [NUM_CH-1:0]                           ch_en,
  output logic [NUM_CH-1:0]                           ch_sq,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] irq_src,
  input  logic [IRQ_W-1:0]                            irq_period,
  input  logic [IRQ_W-1:0]                            irq_match,
  input  logic                                        irq_mode,
  input  logic                                        irq_ack,
  output logic                                        irq,
  output logic                                        irq_overrun
);

  localparam int SRC_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SRC_W:0] NUM_CH_V = (SRC_W + 1)'(NUM_CH);

  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [CNT_W-1:0] div_ch [NUM_CH];

  logic [SRC_W-1:0] src_sel;
  logic             tick;
  logic             match_hit;

  logic [IRQ_W-1:0] icnt_q, icnt_d;
  logic             irq_q, irq_d;
  logic             ovr_q, ovr_d;

  // Per-channel enable/phase decode and next count. Using ">=" rather than
  // "==" means a divisor lowered below the running count still yields exactly
  // one pulse on the next evaluated cycle and then wraps to 0.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_ch[i] = div[i*CNT_W +: CNT_W];
      ch_en[i]  = run && (cnt_q[i] >= div_ch[i]);
      ch_sq[i]  = cnt_q[i] > (div_ch[i] >> 1);
      if (!run) begin
        cnt_d[i] = cnt_q[i];
      end else if (cnt_q[i] >= div_ch[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Channel counter registers; reset dominates run.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Interrupt source select; out-of-range selections fall back to channel 0.
  always_comb begin
    src_sel = irq_src;
    if ({1'b0, irq_src} >= NUM_CH_V) begin
      src_sel = '0;
    end
  end

  assign tick = ch_en[src_sel];

  // A match only counts when the match value lies inside the sequence, so a
  // match above the period can never raise irq (even just after the period
  // is lowered below a running icnt).
  assign match_hit = tick && (icnt_q == irq_match) && (irq_match <= irq_period);

  // Interrupt sequencer next state. Windowed mode updates irq only on ticks,
  // which also makes a latched->windowed mode switch take effect at the next
  // tick. In latched mode a set beats a simultaneous ack, and ack is ignored
  // while run=0 so irq is frozen along with everything else.
  always_comb begin
    icnt_d = icnt_q;
    irq_d  = irq_q;
    ovr_d  = ovr_q;
    if (tick) begin
      icnt_d = (icnt_q >= irq_period) ? '0 : icnt_q + IRQ_W'(1);
    end
    if (!irq_mode) begin
      if (tick) begin
        irq_d = match_hit;
      end
    end else begin
      if (match_hit) begin
        irq_d = 1'b1;
        if (irq_q && !irq_ack) begin
          ovr_d = 1'b1;
        end
      end else if (irq_ack && run) begin
        irq_d = 1'b0;
      end
    end
  end

  // Interrupt sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      icnt_q <= '0;
      irq_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      icnt_q <= icnt_d;
      irq_q  <= irq_d;
      ovr_q  <= ovr_d;
    end
  end

  assign irq         = irq_q;
  assign irq_overrun = ovr_q;

endmodule

// File: tb/tb_clk_en_irq_gen.sv
// Bench for clk_en_irq_gen: directed scenarios with hand-computed literal
// expectations, plus a cycle-by-cycle behavioural model compared on every
// falling edge. Inputs change 1 time unit after the rising edge.
module tb_clk_en_irq_gen;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int IRQ_W  = 4;
  localparam int SRC_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    run;
  logic [NUM_CH*CNT_W-1:0] div;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       ch_sq;
  logic [SRC_W-1:0]        irq_src;
  logic [IRQ_W-1:0]        irq_period;
  logic [IRQ_W-1:0]        irq_match;
  logic                    irq_mode;
  logic                    irq_ack;
  logic                    irq;
  logic                    irq_overrun;

  int n_checks = 0;
  int n_err    = 0;
  bit check_on = 0;
  int hi;

  clk_en_irq_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IRQ_W(IRQ_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .div        (div),
    .ch_en      (ch_en),
    .ch_sq      (ch_sq),
    .irq_src    (irq_src),
    .irq_period (irq_period),
    .irq_match  (irq_match),
    .irq_mode   (irq_mode),
    .irq_ack    (irq_ack),
    .irq        (irq),
    .irq_overrun(irq_overrun)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int divv(input int ch);
    return int'(div[ch*CNT_W +: CNT_W]);
  endfunction

  // ---------------- behavioural model ----------------
  // m_elapsed: clocks since the channel's last pulse; m_pos: position in the
  // interrupt sequence.
  int m_elapsed [NUM_CH];
  int m_pos;
  bit m_irq, m_ovr;
  bit m_fire [NUM_CH];
  bit m_tick, m_hit;
  int m_src;

  initial begin
    for (int i = 0; i < NUM_CH; i++) m_elapsed[i] = 0;
    m_pos = 0; m_irq = 0; m_ovr = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) m_elapsed[i] = 0;
      m_pos = 0; m_irq = 0; m_ovr = 0;
    end else if (run) begin
      for (int i = 0; i < NUM_CH; i++) m_fire[i] = (m_elapsed[i] >= divv(i));
      m_src  = (int'(irq_src) < NUM_CH) ? int'(irq_src) : 0;
      m_tick = m_fire[m_src];
      m_hit  = m_tick && (m_pos == int'(irq_match)) && (int'(irq_match) <= int'(irq_period));
      for (int i = 0; i < NUM_CH; i++) m_elapsed[i] = m_fire[i] ? 0 : m_elapsed[i] + 1;
      if (m_tick) m_pos = (m_pos >= int'(irq_period)) ? 0 : m_pos + 1;
      if (!irq_mode) begin
        if (m_tick) m_irq = m_hit;
      end else if (m_hit) begin
        if (m_irq && !irq_ack) m_ovr = 1;
        m_irq = 1;
      end else if (irq_ack) begin
        m_irq = 0;
      end
    end
  end

  // Compare process: every falling edge once the bench has reset the DUT.
  logic [NUM_CH-1:0] e_en, e_sq;
  always @(negedge clk) begin
    if (check_on) begin
      for (int i = 0; i < NUM_CH; i++) begin
        e_en[i] = run && (m_elapsed[i] >= divv(i));
        e_sq[i] = m_elapsed[i] > (divv(i) / 2);
      end
      chk("model_ch_en", 32'(ch_en), 32'(e_en));
      chk("model_ch_sq", 32'(ch_sq), 32'(e_sq));
      chk("model_irq", 32'(irq), 32'(m_irq));
      chk("model_irq_overrun", 32'(irq_overrun), 32'(m_ovr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int ch, input int v);
    div[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  // Returns at the start of cycle 0 after release (counters at 0).
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic irq_cfg(input int src, input int period, input int match, input bit mode);
    irq_src    = SRC_W'(src);
    irq_period = IRQ_W'(period);
    irq_match  = IRQ_W'(match);
    irq_mode   = mode;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b1; run = 1'b0; div = '0; irq_ack = 1'b0;
    irq_cfg(0, 0, 0, 0);
    set_div(0, 3); set_div(1, 3); set_div(2, 3);
    step();

    // Reset state with run low
    do_reset();
    check_on = 1;
    @(negedge clk);
    chk("rst_ch_en", 32'(ch_en), 32'd0);
    chk("rst_ch_sq", 32'(ch_sq), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_overrun", 32'(irq_overrun), 32'd0);
    step();

    // div0=3: pulses on cycles 3, 7, 11; square high at counts 2 and 3
    run = 1'b1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("div3_ch_en", 32'(ch_en[0]), (c == 3 || c == 7 || c == 11) ? 32'd1 : 32'd0);
      chk("div3_ch_sq", 32'(ch_sq[0]), (c % 4 == 2 || c % 4 == 3) ? 32'd1 : 32'd0);
      step();
    end

    // div0=0: enable every cycle
    set_div(0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("div0_every_cycle", 32'(ch_en[0]), 32'd1);
      step();
    end
    // div0=20, count to 9, lower div0 to 5: one pulse now, then period 6
    set_div(0, 20);
    for (int c = 0; c < 9; c++) step();
    @(negedge clk);
    chk("div20_cnt9_no_pulse", 32'(ch_en[0]), 32'd0);
    set_div(0, 5);
    #1;
    chk("div_lowered_pulse", 32'(ch_en[0]), 32'd1);
    step();
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      chk("div_lowered_period6", 32'(ch_en[0]), (j == 6) ? 32'd1 : 32'd0);
      step();
    end

    // Windowed irq, period 13, match 12, source ch1 with div 7 (tick every 8):
    // irq high for one tick period (8 clocks) every 14 ticks.
    set_div(1, 7);
    irq_cfg(1, 13, 12, 0);
    do_reset();
    hi = 0;
    for (int c = 0; c < 230; c++) begin
      @(negedge clk);
      if (irq) hi++;
      if (c == 103) chk("win_before_rise", 32'(irq), 32'd0);
      if (c == 104) chk("win_rise", 32'(irq), 32'd1);
      if (c == 111) chk("win_last_high", 32'(irq), 32'd1);
      if (c == 112) chk("win_fall", 32'(irq), 32'd0);
      if (c == 216) chk("win_second_rise", 32'(irq), 32'd1);
      step();
    end
    chk("win_high_cycles", 32'(hi), 32'd16);

    // Latched irq via out-of-range source (3 -> ch0, div 1, tick on odd
    // cycles), period 3, match 1: set at cycle 4, overrun at 12, ack at 13.
    set_div(0, 1);
    irq_cfg(3, 3, 1, 1);
    do_reset();
    for (int c = 0; c < 16; c++) begin
      irq_ack = (c == 13);
      @(negedge clk);
      if (c == 4)  chk("latch_set", 32'(irq), 32'd1);
      if (c == 4)  chk("latch_no_ovr", 32'(irq_overrun), 32'd0);
      if (c == 11) chk("latch_held", 32'(irq), 32'd1);
      if (c == 11) chk("latch_ovr_before", 32'(irq_overrun), 32'd0);
      if (c == 12) chk("latch_ovr_set", 32'(irq_overrun), 32'd1);
      if (c == 14) chk("latch_ack_clears", 32'(irq), 32'd0);
      if (c == 14) chk("latch_ovr_sticky", 32'(irq_overrun), 32'd1);
      step();
    end
    irq_ack = 1'b0;

    // Ack coinciding with a match tick (cycle 11): set wins, no overrun.
    // Then switch to windowed at cycle 12 with ack held: ack ignored, irq
    // drops at the next tick (cycle 13, position 2).
    do_reset();
    for (int c = 0; c < 16; c++) begin
      irq_ack  = (c == 11 || c == 12);
      irq_mode = (c >= 12) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 12) chk("ack_vs_set_irq", 32'(irq), 32'd1);
      if (c == 12) chk("ack_vs_set_ovr", 32'(irq_overrun), 32'd0);
      if (c == 13) chk("mode0_ack_ignored", 32'(irq), 32'd1);
      if (c == 14) chk("mode0_next_tick", 32'(irq), 32'd0);
      step();
    end
    irq_ack = 1'b0;

    // Match above period never raises irq
    irq_cfg(0, 2, 3, 0);
    do_reset();
    hi = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (irq) hi++;
      step();
    end
    chk("match_gt_period", 32'(hi), 32'd0);

    // run=0 for 50 cycles with irq latched, then rst mid-sequence
    irq_cfg(3, 3, 1, 1);
    do_reset();
    for (int c = 0; c < 13; c++) step();
    run = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 0 || c == 49) begin
        chk("frozen_ch_en", 32'(ch_en), 32'd0);
        chk("frozen_irq", 32'(irq), 32'd1);
        chk("frozen_ovr", 32'(irq_overrun), 32'd1);
      end
      step();
    end
    run = 1'b1;
    rst = 1'b1;
    irq_ack = 1'b1;
    step();
    rst = 1'b0;
    irq_ack = 1'b0;
    @(negedge clk);
    chk("post_rst_ch_en", 32'(ch_en), 32'd0);
    chk("post_rst_ch_sq", 32'(ch_sq), 32'd0);
    chk("post_rst_irq", 32'(irq), 32'd0);
    chk("post_rst_ovr", 32'(irq_overrun), 32'd0);
    step();

    check_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
